// File: rtl/sdram_init_seq.sv
// SDR SDRAM power-up command sequencer: CKE, PRECHARGE ALL, REF_NUM x AUTO REFRESH, LOAD MODE, then INIT_DONE.
// Optional SDRAM_INIT_EMR_EN adds a SET_MODE-gated extended mode register load (BA=2'b10) before INIT_DONE.
module sdram_init_seq #(
    parameter int ADDR_W = 13,
    parameter int BA_W = 2,
    parameter int T_RP = 3,
    parameter int T_RFC = 8,
    parameter int T_MRD = 2,
    parameter int REF_NUM = 8,
    parameter logic [ADDR_W-1:0] MODE_REG = 13'h037,
    parameter logic [ADDR_W-1:0] EMR_VAL = 13'h000
) (
    input  logic              sdram_clk,
    input  logic              sdram_rst,
    input  logic              PAA,
    input  logic              SET_MODE,
    output logic              CKE,
    output logic              CS_N,
    output logic              RAS_N,
    output logic              CAS_N,
    output logic              WE_N,
    output logic [BA_W-1:0]   BA,
    output logic [ADDR_W-1:0] ADDR,
    output logic              INIT_DONE
);

    // {CS_N, RAS_N, CAS_N, WE_N}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;

    localparam logic [7:0] RP_LD  = 8'(T_RP - 1);
    localparam logic [7:0] RFC_LD = 8'(T_RFC - 1);
    localparam logic [7:0] MRD_LD = 8'(T_MRD - 1);
    localparam logic [3:0] REF_N  = 4'(REF_NUM);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_WAIT_RP,
        S_WAIT_RFC,
        S_WAIT_SET,
        S_LMR,
        S_WAIT_MRD,
`ifdef SDRAM_INIT_EMR_EN
        S_WAIT_SET_EMR,
        S_EMR,
        S_WAIT_EMRD,
`endif
        S_DONE
    } state_t;

    state_t            state_q, state_nxt;
    logic [7:0]        wait_q, wait_nxt;
    logic [3:0]        ref_q, ref_nxt;
    logic [3:0]        cmd_q, cmd_nxt;
    logic [BA_W-1:0]   ba_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              cke_nxt, done_nxt;

    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            ref_q     <= '0;
            cmd_q     <= CMD_NOP;
            BA        <= '0;
            ADDR      <= '0;
            CKE       <= 1'b0;
            INIT_DONE <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            wait_q    <= wait_nxt;
            ref_q     <= ref_nxt;
            cmd_q     <= cmd_nxt;
            BA        <= ba_nxt;
            ADDR      <= addr_nxt;
            CKE       <= cke_nxt;
            INIT_DONE <= done_nxt;
        end
    end

    assign {CS_N, RAS_N, CAS_N, WE_N} = cmd_q;

    // A wait state issues the next command on the same edge its counter reads zero,
    // so command-to-command spacing equals T_x exactly.
    always_comb begin
        state_nxt = state_q;
        wait_nxt  = (wait_q != 8'd0) ? wait_q - 8'd1 : wait_q;
        ref_nxt   = ref_q;
        cmd_nxt   = CMD_NOP;
        ba_nxt    = '0;
        addr_nxt  = '0;
        cke_nxt   = CKE;
        done_nxt  = INIT_DONE;
        case (state_q)
            S_IDLE: begin
                if (PAA) begin
                    cke_nxt   = 1'b1;
                    state_nxt = S_PRE;
                end
            end
            S_PRE: begin
                cmd_nxt      = CMD_PRE;
                addr_nxt[10] = 1'b1;
                wait_nxt     = RP_LD;
                state_nxt    = S_WAIT_RP;
            end
            S_WAIT_RP, S_WAIT_RFC: begin
                if (wait_q == 8'd0) begin
                    if (state_q == S_WAIT_RP || ref_q < REF_N) begin
                        cmd_nxt   = CMD_REF;
                        wait_nxt  = RFC_LD;
                        ref_nxt   = ref_q + 4'd1;
                        state_nxt = S_WAIT_RFC;
                    end else if (SET_MODE) begin
                        cmd_nxt   = CMD_LMR;
                        addr_nxt  = MODE_REG;
                        wait_nxt  = MRD_LD;
                        state_nxt = S_WAIT_MRD;
                    end else begin
                        state_nxt = S_WAIT_SET;
                    end
                end
            end
            S_WAIT_SET: begin
                if (SET_MODE) state_nxt = S_LMR;
            end
            S_LMR: begin
                cmd_nxt   = CMD_LMR;
                addr_nxt  = MODE_REG;
                wait_nxt  = MRD_LD;
                state_nxt = S_WAIT_MRD;
            end
`ifdef SDRAM_INIT_EMR_EN
            S_WAIT_MRD: begin
                if (wait_q == 8'd0) begin
                    if (SET_MODE) begin
                        cmd_nxt   = CMD_LMR;
                        ba_nxt    = BA_W'(2'b10);
                        addr_nxt  = EMR_VAL;
                        wait_nxt  = MRD_LD;
                        state_nxt = S_WAIT_EMRD;
                    end else begin
                        state_nxt = S_WAIT_SET_EMR;
                    end
                end
            end
            S_WAIT_SET_EMR: begin
                if (SET_MODE) state_nxt = S_EMR;
            end
            S_EMR: begin
                cmd_nxt   = CMD_LMR;
                ba_nxt    = BA_W'(2'b10);
                addr_nxt  = EMR_VAL;
                wait_nxt  = MRD_LD;
                state_nxt = S_WAIT_EMRD;
            end
            S_WAIT_EMRD: begin
                if (wait_q == 8'd0) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_DONE;
                end
            end
`else
            S_WAIT_MRD: begin
                if (wait_q == 8'd0) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_DONE;
                end
            end
`endif
            S_DONE: begin
                cke_nxt  = 1'b1;
                done_nxt = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sdram_init_seq.sv
// Directed bench: two sequencer instances (REF_NUM=2/T_RFC=8 and REF_NUM=1/T_RFC=1) checked cycle by cycle.
module tb_sdram_init_seq;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] LMR = 4'b0000;

    logic sdram_clk = 1'b0;
    logic sdram_rst, PAA, SET_MODE;

    logic a_CKE, a_CS_N, a_RAS_N, a_CAS_N, a_WE_N, a_INIT_DONE;
    logic [1:0] a_BA;
    logic [12:0] a_ADDR;
    logic b_CKE, b_CS_N, b_RAS_N, b_CAS_N, b_WE_N, b_INIT_DONE;
    logic [1:0] b_BA;
    logic [12:0] b_ADDR;

    logic [3:0] a_cmd, b_cmd;
    assign a_cmd = {a_CS_N, a_RAS_N, a_CAS_N, a_WE_N};
    assign b_cmd = {b_CS_N, b_RAS_N, b_CAS_N, b_WE_N};

    int total = 0;
    int fails = 0;

    sdram_init_seq #(.T_RP(3), .T_RFC(8), .T_MRD(2), .REF_NUM(2),
                     .MODE_REG(13'h037), .EMR_VAL(13'h020)) dut_a (
        .sdram_clk(sdram_clk), .sdram_rst(sdram_rst), .PAA(PAA), .SET_MODE(SET_MODE),
        .CKE(a_CKE), .CS_N(a_CS_N), .RAS_N(a_RAS_N), .CAS_N(a_CAS_N), .WE_N(a_WE_N),
        .BA(a_BA), .ADDR(a_ADDR), .INIT_DONE(a_INIT_DONE));

    sdram_init_seq #(.T_RP(3), .T_RFC(1), .T_MRD(2), .REF_NUM(1),
                     .MODE_REG(13'h037), .EMR_VAL(13'h020)) dut_b (
        .sdram_clk(sdram_clk), .sdram_rst(sdram_rst), .PAA(PAA), .SET_MODE(SET_MODE),
        .CKE(b_CKE), .CS_N(b_CS_N), .RAS_N(b_RAS_N), .CAS_N(b_CAS_N), .WE_N(b_WE_N),
        .BA(b_BA), .ADDR(b_ADDR), .INIT_DONE(b_INIT_DONE));

    always #5 sdram_clk = ~sdram_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sdram_clk);
        #1;
    endtask

    // Expected {INIT_DONE, CKE, cmd, BA, ADDR} image of an instance at a given point.
    function automatic logic [31:0] img(input logic done, input logic cke, input logic [3:0] cmd,
                                        input logic [1:0] ba, input logic [12:0] addr);
        return {11'd0, done, cke, cmd, ba, addr};
    endfunction

    logic [31:0] a_img, b_img;
    assign a_img = img(a_INIT_DONE, a_CKE, a_cmd, a_BA, a_ADDR);
    assign b_img = img(b_INIT_DONE, b_CKE, b_cmd, b_BA, b_ADDR);

    localparam logic [31:0] RST_IMG = {11'd0, 1'b0, 1'b0, 4'b0111, 2'b00, 13'h0000};

    // Expected image for a running sequence, given command edges and done edge.
    function automatic logic [31:0] exp_img(input int k, input int k_pre, input int k_ref1, input int k_ref2,
                                            input int k_lmr, input int k_emr, input int k_done);
        logic [3:0] c;
        logic [1:0] ba;
        logic [12:0] ad;
        c = NOP; ba = 2'b00; ad = 13'h0;
        if (k == k_pre) begin c = PRE; ad = 13'h0400; end
        else if (k == k_ref1 || k == k_ref2) c = REF;
        else if (k == k_lmr) begin c = LMR; ad = 13'h037; end
        else if (k == k_emr) begin c = LMR; ba = 2'b10; ad = 13'h020; end
        return img(k >= k_done, 1'b1, c, ba, ad);
    endfunction

`ifdef SDRAM_INIT_EMR_EN
    localparam int EMR_ON = 1;
`else
    localparam int EMR_ON = 0;
`endif

    int b_refs;

    initial begin
        sdram_rst = 1'b1;
        PAA = 1'b0;
        SET_MODE = 1'b1;
        tick();
        chk("reset_a", a_img, RST_IMG);
        chk("reset_b", b_img, RST_IMG);
        for (int i = 0; i < 4; i++) begin
            PAA = ~PAA;
            tick();
            chk("reset_paa_a", a_img, RST_IMG);
            chk("reset_paa_b", b_img, RST_IMG);
        end

        // Scenario 1: SET_MODE high, PAA dropped so it is sampled low from N+5.
        @(negedge sdram_clk);
        sdram_rst = 1'b0;
        PAA = 1'b0;
        tick();
        tick();
        chk("idle_a", a_img, RST_IMG);
        @(negedge sdram_clk);
        PAA = 1'b1;
        tick();
        chk("cke_at_n_a", a_img, img(1'b0, 1'b1, NOP, 2'b00, 13'h0));
        chk("cke_at_n_b", b_img, img(1'b0, 1'b1, NOP, 2'b00, 13'h0));
        b_refs = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 4) PAA = 1'b0;
            if (b_cmd == REF) b_refs++;
            chk($sformatf("s1_a_k%0d", k), a_img,
                exp_img(k, 1, 4, 12, 20, EMR_ON ? 22 : -1, EMR_ON ? 24 : 22));
            chk($sformatf("s1_b_k%0d", k), b_img,
                exp_img(k, 1, 4, -1, 5, EMR_ON ? 7 : -1, EMR_ON ? 9 : 7));
        end
        chk("s1_b_ref_count", 32'(b_refs), 32'd1);
        for (int k = 0; k < 100; k++) begin
            PAA = k[0];
            SET_MODE = k[1];
            tick();
            chk("park_a", a_img, img(1'b1, 1'b1, NOP, 2'b00, 13'h0));
            chk("park_b", b_img, img(1'b1, 1'b1, NOP, 2'b00, 13'h0));
        end

        // Scenario 2: SET_MODE held low until it is sampled high at N+30.
        @(negedge sdram_clk);
        sdram_rst = 1'b1;
        PAA = 1'b0;
        SET_MODE = 1'b0;
        @(negedge sdram_clk);
        sdram_rst = 1'b0;
        @(negedge sdram_clk);
        PAA = 1'b1;
        tick();
        chk("s2_cke_at_n", a_img, img(1'b0, 1'b1, NOP, 2'b00, 13'h0));
        for (int k = 1; k <= 36; k++) begin
            tick();
            if (k == 29) SET_MODE = 1'b1;
            chk($sformatf("s2_a_k%0d", k), a_img,
                exp_img(k, 1, 4, 12, 31, EMR_ON ? 33 : -1, EMR_ON ? 35 : 33));
            chk($sformatf("s2_b_k%0d", k), b_img,
                exp_img(k, 1, 4, -1, 31, EMR_ON ? 33 : -1, EMR_ON ? 35 : 33));
        end

        // Scenario 3: asynchronous reset in the middle of WAIT_RFC, then a clean restart.
        @(negedge sdram_clk);
        sdram_rst = 1'b1;
        PAA = 1'b0;
        SET_MODE = 1'b1;
        @(negedge sdram_clk);
        sdram_rst = 1'b0;
        @(negedge sdram_clk);
        PAA = 1'b1;
        tick();
        for (int k = 1; k <= 6; k++) tick();
        chk("s3_pre_reset_cke", 32'(a_CKE), 32'd1);
        #2;
        sdram_rst = 1'b1;
        #1;
        chk("s3_async_rst_a", a_img, RST_IMG);
        chk("s3_async_rst_b", b_img, RST_IMG);
        @(negedge sdram_clk);
        sdram_rst = 1'b0;
        PAA = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("s3_idle_after_rst", a_img, RST_IMG);
        end
        @(negedge sdram_clk);
        PAA = 1'b1;
        tick();
        chk("s3_restart_cke", a_img, img(1'b0, 1'b1, NOP, 2'b00, 13'h0));
        tick();
        chk("s3_restart_pre", a_img, img(1'b0, 1'b1, PRE, 2'b00, 13'h0400));

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/sdram_init_seq.md
Name: sdram_init_seq

Overview:
- Consumer of the power-up handshake (PAA, SET_MODE) produced by the SDRAM power-up delay block.
- Once PAA is seen, drives the JEDEC SDR SDRAM initialization command sequence: CKE high, PRECHARGE ALL, REF_NUM × AUTO REFRESH, then LOAD MODE REGISTER.
- Asserts INIT_DONE when the sequence completes. The SDRAM controller arbiter then takes over the command bus.

Parameters:
- ADDR_W, 13, SDRAM address bus width (≥11).
- BA_W, 2, bank address width.
- T_RP, 3, PRECHARGE-to-next-command spacing in sdram_clk cycles (1..255).
- T_RFC, 8, REFRESH-to-next-command spacing in cycles (1..255).
- T_MRD, 2, LOAD MODE-to-INIT_DONE spacing in cycles (1..255).
- REF_NUM, 8, number of AUTO REFRESH commands (1..15).
- MODE_REG, 13'h037, value driven on addr during LOAD MODE (CL3, sequential, full page).
- EMR_VAL, 13'h000, extended mode value; used only with the optional feature.

Ports:
- sdram_clk  in  1  SDRAM domain clock.
- sdram_rst  in  1  asynchronous, active-high reset.
- PAA  in  1  power-up delay elapsed; level, sampled on rising edge.
- SET_MODE  in  1  mode register programming permitted; level.
- CKE  out  1  SDRAM clock enable.
- CS_N  out  1  chip select, active-low.
- RAS_N  out  1  row address strobe, active-low.
- CAS_N  out  1  column address strobe, active-low.
- WE_N  out  1  write enable, active-low.
- BA  out  BA_W  bank address.
- ADDR  out  ADDR_W  address bus.
- INIT_DONE  out  1  initialization complete; sticky until reset.

Behaviour:
- All outputs are registered.
- Reset values:
  - CKE=0, INIT_DONE=0, BA=0, ADDR=0.
  - Command = NOP (CS_N=0, RAS_N=1, CAS_N=1, WE_N=1).
  - State = IDLE, wait counter = 0, refresh counter = 0.
- Command encodings, each driven for exactly one cycle with NOP otherwise:
  - PRE: RAS_N=0, CAS_N=1, WE_N=0, ADDR[10]=1.
  - REF: RAS_N=0, CAS_N=0, WE_N=1.
  - LMR: RAS_N=0, CAS_N=0, WE_N=0, BA=0, ADDR=MODE_REG.
- States: IDLE → PRE → WAIT_RP → REF → WAIT_RFC → (REF while refs issued < REF_NUM, else LMR) → WAIT_MRD → DONE.
- IDLE: NOP, CKE=0. If PAA is sampled high at edge N, CKE=1 from edge N.
- PRE is on the bus from edge N+1.
- Command spacing is exactly the parameter: next command (or INIT_DONE) appears T_x edges after the previous command edge.
- WAIT_RFC exit: 4-bit refresh counter increments per REF; after REF_NUM refreshes go to LMR.
- LMR gating: LMR is issued only when SET_MODE=1 at the edge the wait expires. Otherwise hold NOP in a WAIT_SET state; LMR appears one edge after SET_MODE is sampled high.
- DONE: INIT_DONE=1 and CKE=1 held; command bus parked at NOP with BA/ADDR=0. Remains in DONE regardless of PAA/SET_MODE until reset.
- PAA falling after leaving IDLE is ignored.
- Reset asserted mid-sequence: immediate return to reset values, including CKE=0. The sequence restarts from IDLE after release.
- Wait counter is 8 bits; it loads T_x-1 on command issue and decrements to 0. No wrap is possible within the legal parameter range.

Optional Feature:
- Macro SDRAM_INIT_EMR_EN.
- Defined: after WAIT_MRD, add states EMR → WAIT_EMRD.
  - EMR command = LMR encoding with BA=2'b10, ADDR=EMR_VAL (mobile SDRAM extended mode register).
  - Spacing T_MRD; INIT_DONE is asserted T_MRD after EMR.
  - EMR is also gated by SET_MODE, same as LMR.
- Undefined: no EMR states; INIT_DONE is asserted T_MRD after LMR.

Test Plan:
- Reset held, PAA toggled → CKE=0, NOP, INIT_DONE=0 throughout; asserting reset mid-WAIT_RFC → outputs return to reset values within the same cycle (asynchronous).
- T_RP=3, T_RFC=8, REF_NUM=2, T_MRD=2, SET_MODE=1, PAA rises and is sampled at edge N → CKE=1 at N; PRE at N+1 (ADDR[10]=1); REF at N+4 and N+12; LMR at N+20 with ADDR=13'h037, BA=0; INIT_DONE=1 at N+22. Every other cycle is NOP.
- Same config with SET_MODE=0 until edge N+30 → NOP cycles N+20..N+30; LMR at N+31; INIT_DONE at N+33.
- PAA deasserted at N+5 → sequence unaffected; INIT_DONE at N+22; afterwards INIT_DONE stays 1 and the bus stays at NOP for 100 cycles.
- REF_NUM=1, T_RFC=1 → REF and LMR on consecutive edges; REF count equals 1 exactly.
- SDRAM_INIT_EMR_EN defined, EMR_VAL=13'h020 → EMR at N+22 with BA=2'b10, ADDR=13'h020; INIT_DONE at N+24.
